dff_stream_deserializer: RTL and testbench
==========================================

// Module: dff_stream_deserializer
// PURPOSE
//  Downstream consumer of the DFF sim cell's registered Q stream.
//  Collects WIDTH serial bits, qualified by a valid/ready handshake, into a
//  parallel word and presents that word on a double-buffered valid/ready output.
//  Serves as the capture stage in the VTR whitebox tests that chain DFF cells into
//  serial paths; also a reference for v2x timing extraction of multi-register paths.
// PARAMETERS
//  WIDTH      8   bits per output word; legal range 2..32
//  MSB_FIRST  1   1: first accepted bit lands in Q[WIDTH-1]; 0: first bit lands in Q[0]
//  CNT_W      16  width of the delivered-word counter WORDS
// PORTS
//  CLK      input   1        rising-edge clock for all state
//  RSTN     input   1        asynchronous active-low reset
//  D        input   1        serial data bit, taken from upstream DFF Q
//  D_VALID  input   1        D is valid this cycle
//  D_READY  output  1        block accepts D this cycle
//  FLUSH    input   1        synchronous; discard partially collected word
//  Q        output  WIDTH    assembled word (registered)
//  Q_VALID  output  1        Q holds an undelivered word
//  Q_READY  input   1        downstream accepts Q this cycle
//  WORDS    output  CNT_W    count of words delivered (Q_VALID&&Q_READY); wraps
// BEHAVIOUR
//  Reset (RSTN=0, async): SR=0, CNT=0, Q=0, Q_VALID=0, WORDS=0. D_READY=1 once RSTN=1.
//  An input bit is accepted at a CLK posedge when D_VALID && D_READY && !FLUSH.
//  An output word is taken at a CLK posedge when Q_VALID && Q_READY.
//  Internal state:
//   - Shift reg SR[WIDTH-2:0] and CNT (0..WIDTH-1).
//   - Output reg Q with Q_VALID.
//  Collection states, derived from CNT:
//   - EMPTY   CNT==0.
//   - PARTIAL 0<CNT<WIDTH-1.
//   - LAST    CNT==WIDTH-1; the next accepted bit completes the word.
//  Accepting a bit in EMPTY or PARTIAL:
//   - SR shifts in D, CNT+1.
//   - MSB_FIRST=1 shifts toward the MSB. MSB_FIRST=0 shifts toward the LSB.
//  Accepting a bit in LAST:
//   - Q loads the full word {SR,D} (ordered per MSB_FIRST).
//   - Q_VALID=1 and CNT=0 at the same edge. SR contents are don't-care.
//  Latency: Q_VALID rises on the posedge that accepts the WIDTH-th bit.
//   - Full word visible 1 cycle after the last bit is presented.
//   - Input throughput is 1 bit/cycle.
//  D_READY is combinational: D_READY = !(CNT==WIDTH-1 && Q_VALID && !Q_READY).
//   - Only a completing bit stalls, and only while the output is held.
//   - This is the only comb path from Q_READY to D_READY.
//  Simultaneous take and completing bit: Q reloads the new word, Q_VALID stays 1.
//   - No bubble, no loss.
//  Take with no completing bit: Q_VALID -> 0. Q holds its last value.
//  WORDS increments by 1 on every take and wraps from 2^CNT_W-1 to 0.
//  FLUSH=1:
//   - CNT -> 0 and any bit offered that cycle is dropped.
//   - Q, Q_VALID and WORDS are unaffected; a take in the same cycle still completes.
//  D_VALID=0 holds SR and CNT. A word never completes without WIDTH accepted bits.
//  Mid-operation reset discards partial and held words immediately (async).
//   - Outputs go to their reset values with no clock required.
// TESTING
//  1. WIDTH=8, MSB_FIRST=1, Q_READY=1, bits 1,0,1,1,0,0,1,0 on consecutive cycles:
//     Q=8'hB2 and Q_VALID=1 for one cycle, 1 cycle after the 8th bit. WORDS=1.
//  2. Same bits with MSB_FIRST=0: Q=8'h4D.
//  3. Q_READY=0, stream 16 bits (0xA5 then 0x3C):
//     Q=0xA5 is held; D_READY drops only while the 16th bit waits.
//     Raise Q_READY: 0xA5 is taken, 0x3C loads on the same edge, no bits lost.
//  4. 5 bits, then FLUSH=1 with D_VALID=1, then 8 bits of 0xFF:
//     Q=0xFF. The flushed bits and the bit offered during FLUSH do not appear.
//  5. Deassert RSTN asynchronously mid-word and while Q_VALID=1:
//     Q_VALID, Q, WORDS and CNT go to 0 with no clock.
//     The next 8 bits form a clean word.
//  6. CNT_W=4, deliver 17 words back-to-back:
//     WORDS wraps 15->0 and reads 1; continuous D_VALID gives one word every 8 cycles.

Source files
------------

// File: rtl/dff_stream_deserializer.sv
// ----------------------------------------------------------------------------
// dff_stream_deserializer
//
// Capture stage for a chain of DFF cells. Serial bits arrive from an upstream
// register's Q output under a valid/ready handshake and are assembled into a
// WIDTH-bit word. The finished word is presented on a registered valid/ready
// output. The shift register and the output register together act as a
// double buffer, so a new word can be collected while the previous word is
// still waiting for downstream.
//
// Parameters
//   WIDTH      bits per output word (2..32)
//   MSB_FIRST  1: first accepted bit ends up in Q[WIDTH-1]
//              0: first accepted bit ends up in Q[0]
//   CNT_W      width of the delivered-word counter WORDS
//
// Ports
//   CLK      in   rising-edge clock for all state
//   RSTN     in   asynchronous active-low reset
//   D        in   serial data bit
//   D_VALID  in   D is valid this cycle
//   D_READY  out  block accepts D this cycle (combinational)
//   FLUSH    in   synchronous discard of the partially collected word
//   Q        out  assembled word (registered)
//   Q_VALID  out  Q holds an undelivered word
//   Q_READY  in   downstream accepts Q this cycle
//   WORDS    out  number of words delivered, wraps at 2^CNT_W
// ----------------------------------------------------------------------------
module dff_stream_deserializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1,
    parameter int CNT_W     = 16
) (
    input  logic             CLK,
    input  logic             RSTN,
    input  logic             D,
    input  logic             D_VALID,
    output logic             D_READY,
    input  logic             FLUSH,
    output logic [WIDTH-1:0] Q,
    output logic             Q_VALID,
    input  logic             Q_READY,
    output logic [CNT_W-1:0] WORDS
);

    // Bit counter only needs to reach WIDTH-1; the WIDTH-th bit is never
    // stored in the shift register, it goes straight into Q.
    localparam int              CW       = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]   LAST_CNT = CW'(WIDTH - 1);

    // Collection phase decoded from the bit count.
    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        PARTIAL = 2'd1,
        LAST    = 2'd2
    } phase_t;

    logic [WIDTH-2:0] sr;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] q_reg;
    logic             q_valid_reg;
    logic [CNT_W-1:0] words_reg;

    phase_t           phase;
    logic             d_ready;
    logic             accept;
    logic             take;
    logic             complete;
    logic [WIDTH-2:0] d_vec;
    logic [WIDTH-2:0] sr_next;
    logic [WIDTH-1:0] word_next;

    // Phase decode from the counter.
    always_comb begin
        phase = PARTIAL;
        if (cnt == '0) begin
            phase = EMPTY;
        end else if (cnt == LAST_CNT) begin
            phase = LAST;
        end
    end

    // Only a completing bit can stall, and only while the output register is
    // still occupied and not being drained in the same cycle.
    always_comb begin
        d_ready  = !((phase == LAST) && q_valid_reg && !Q_READY);
        accept   = D_VALID && d_ready && !FLUSH;
        take     = q_valid_reg && Q_READY;
        complete = accept && (phase == LAST);
    end

    // Next shift register value and the completed word. D is placed in a
    // zero-filled vector so the shifts stay well-formed even when WIDTH=2
    // and the shift register is a single bit.
    always_comb begin
        d_vec    = '0;
        d_vec[0] = D;
        if (MSB_FIRST) begin
            sr_next   = (sr << 1) | d_vec;
            word_next = {sr, D};
        end else begin
            sr_next   = (sr >> 1) | (d_vec << (WIDTH - 2));
            word_next = {D, sr};
        end
    end

    // Input side: bit count and shift register. FLUSH wins over an offered
    // bit, so the bit presented during a flush is dropped.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            sr  <= '0;
            cnt <= '0;
        end else if (FLUSH) begin
            cnt <= '0;
        end else if (accept) begin
            if (complete) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
                sr  <= sr_next;
            end
        end
    end

    // Output side: a completing bit reloads Q even when the previous word is
    // being taken on the same edge, so Q_VALID stays high with no bubble.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            q_reg       <= '0;
            q_valid_reg <= 1'b0;
        end else if (complete) begin
            q_reg       <= word_next;
            q_valid_reg <= 1'b1;
        end else if (take) begin
            q_valid_reg <= 1'b0;
        end
    end

    // Delivered-word counter, wraps naturally.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            words_reg <= '0;
        end else if (take) begin
            words_reg <= words_reg + 1'b1;
        end
    end

    assign D_READY = d_ready;
    assign Q       = q_reg;
    assign Q_VALID = q_valid_reg;
    assign WORDS   = words_reg;

endmodule

// File: tb/tb_dff_stream_deserializer.sv
// ----------------------------------------------------------------------------
// tb_dff_stream_deserializer
//
// Two instances share one input stream: dutA is MSB-first with a 16-bit word
// counter, dutB is LSB-first with a 4-bit word counter so counter wrap is
// reachable quickly. Inputs change on the falling edge; outputs are checked
// 1 time unit later, well away from the rising edge.
// ----------------------------------------------------------------------------
module tb_dff_stream_deserializer;

    logic        clk = 1'b0;
    logic        rstn;
    logic        d;
    logic        dValid;
    logic        flush;
    logic        qReady;

    logic        dReadyA;
    logic        qValidA;
    logic [7:0]  qA;
    logic [15:0] wordsA;

    logic        dReadyB;
    logic        qValidB;
    logic [7:0]  qB;
    logic [3:0]  wordsB;

    int checkCount = 0;
    int passCount  = 0;

    always #5 clk = ~clk;

    dff_stream_deserializer #(.WIDTH(8), .MSB_FIRST(1'b1), .CNT_W(16)) dutA (
        .CLK(clk), .RSTN(rstn), .D(d), .D_VALID(dValid), .D_READY(dReadyA),
        .FLUSH(flush), .Q(qA), .Q_VALID(qValidA), .Q_READY(qReady), .WORDS(wordsA)
    );

    dff_stream_deserializer #(.WIDTH(8), .MSB_FIRST(1'b0), .CNT_W(4)) dutB (
        .CLK(clk), .RSTN(rstn), .D(d), .D_VALID(dValid), .D_READY(dReadyB),
        .FLUSH(flush), .Q(qB), .Q_VALID(qValidB), .Q_READY(qReady), .WORDS(wordsB)
    );

    // One comparison: counts it, and counts a pass or reports the failure.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    endtask

    // Drive one cycle of inputs on the falling edge, then settle briefly.
    task automatic applyStimulus(input logic bitIn, input logic validIn,
                                 input logic flushIn, input logic readyIn);
        @(negedge clk);
        d      = bitIn;
        dValid = validIn;
        flush  = flushIn;
        qReady = readyIn;
        #1;
    endtask

    // Eight consecutive valid bits, most significant bit of value first.
    task automatic sendByte(input logic [7:0] value, input logic readyIn);
        for (int k = 0; k < 8; k++) begin
            applyStimulus(value[7-k], 1'b1, 1'b0, readyIn);
        end
    endtask

    initial begin
        logic [7:0] pat;

        rstn   = 1'b0;
        d      = 1'b0;
        dValid = 1'b0;
        flush  = 1'b0;
        qReady = 1'b1;

        // Reset state
        #12;
        checkOutput("rst_qvalid", 32'(qValidA), 32'h0);
        checkOutput("rst_q",      32'(qA),      32'h0);
        checkOutput("rst_words",  32'(wordsA),  32'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        rstn = 1'b1;
        #1;
        checkOutput("rst_dready", 32'(dReadyA), 32'h1);

        // Bits 1,0,1,1,0,0,1,0: MSB-first gives B2, LSB-first gives 4D
        sendByte(8'hB2, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("t1_qvalid", 32'(qValidA), 32'h1);
        checkOutput("t1_qA",     32'(qA),      32'hB2);
        checkOutput("t2_qB",     32'(qB),      32'h4D);
        checkOutput("t1_words0", 32'(wordsA),  32'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("t1_qvalid_drop", 32'(qValidA), 32'h0);
        checkOutput("t1_words1",      32'(wordsA),  32'h1);
        checkOutput("t1_q_hold",      32'(qA),      32'hB2);

        // Output held: A5 then 3C streamed with Q_READY low
        sendByte(8'hA5, 1'b0);
        pat = 8'h3C;
        for (int k = 0; k < 7; k++) begin
            applyStimulus(pat[7-k], 1'b1, 1'b0, 1'b0);
            if (k == 0) begin
                checkOutput("t3_qvalid_a5", 32'(qValidA), 32'h1);
                checkOutput("t3_q_a5",      32'(qA),      32'hA5);
                checkOutput("t3_dready_mid", 32'(dReadyA), 32'h1);
            end
        end
        applyStimulus(pat[0], 1'b1, 1'b0, 1'b0);
        checkOutput("t3_dready_stall", 32'(dReadyA), 32'h0);
        applyStimulus(pat[0], 1'b1, 1'b0, 1'b0);
        checkOutput("t3_dready_stall2", 32'(dReadyA), 32'h0);
        checkOutput("t3_q_held",        32'(qA),      32'hA5);
        applyStimulus(pat[0], 1'b1, 1'b0, 1'b1);
        checkOutput("t3_dready_release", 32'(dReadyA), 32'h1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("t3_qA_3c",    32'(qA),      32'h3C);
        checkOutput("t3_qB_3c",    32'(qB),      32'h3C);
        checkOutput("t3_qvalid",   32'(qValidA), 32'h1);
        checkOutput("t3_words2",   32'(wordsA),  32'h2);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("t3_qvalid_drop", 32'(qValidA), 32'h0);
        checkOutput("t3_words3",      32'(wordsA),  32'h3);

        // Flush: 5 zero bits, flush with a bit offered, then 8 ones
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
        end
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
        sendByte(8'hFF, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("t4_qvalid", 32'(qValidA), 32'h1);
        checkOutput("t4_qA",     32'(qA),      32'hFF);
        checkOutput("t4_qB",     32'(qB),      32'hFF);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("t4_words4", 32'(wordsA),  32'h4);

        // Asynchronous reset with a held word and a partial word in flight
        sendByte(8'h5A, 1'b0);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("t5_pre_qvalid", 32'(qValidA), 32'h1);
        #1;
        rstn = 1'b0;
        #1;
        checkOutput("t5_async_qvalid", 32'(qValidA), 32'h0);
        checkOutput("t5_async_q",      32'(qA),      32'h0);
        checkOutput("t5_async_words",  32'(wordsA),  32'h0);
        checkOutput("t5_async_wordsB", 32'(wordsB),  32'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        rstn = 1'b1;
        sendByte(8'hC3, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("t5_clean_qvalid", 32'(qValidA), 32'h1);
        checkOutput("t5_clean_q",      32'(qA),      32'hC3);
        checkOutput("t5_clean_words",  32'(wordsA),  32'h0);

        // 17 back-to-back words with continuous D_VALID; word w carries value w
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        rstn = 1'b0;
        #2;
        rstn = 1'b1;
        for (int w = 0; w < 17; w++) begin
            pat = 8'(w);
            for (int k = 0; k < 8; k++) begin
                applyStimulus(pat[7-k], 1'b1, 1'b0, 1'b1);
                if (k == 0 && w > 0) begin
                    checkOutput($sformatf("t6_qvalid_w%0d", w - 1), 32'(qValidA), 32'h1);
                    checkOutput($sformatf("t6_q_w%0d", w - 1),      32'(qA),      32'(w - 1));
                    checkOutput($sformatf("t6_wordsB_w%0d", w - 1), 32'(wordsB),  32'((w - 1) % 16));
                end
                if (k == 4) begin
                    checkOutput($sformatf("t6_gap_w%0d", w), 32'(qValidA), 32'h0);
                end
            end
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("t6_qvalid_w16", 32'(qValidA), 32'h1);
        checkOutput("t6_q_w16",      32'(qA),      32'h10);
        checkOutput("t6_wordsB_wrap", 32'(wordsB), 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("t6_wordsA_17", 32'(wordsA),  32'd17);
        checkOutput("t6_wordsB_1",  32'(wordsB),  32'h1);
        checkOutput("t6_qvalid_end", 32'(qValidA), 32'h0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
